// File: rtl/drum_strike_trigger.sv
`default_nettype none
// ============================================================================
// Module      : drum_strike_trigger
// Description : Turns a stream of gyro pitch-rate samples into drum hit
//               events. A fast downward swing arms the detector, the peak
//               rate is tracked, and the slow-down (or reversal) that marks
//               the stick striking the pad emits one hit with a zone and a
//               velocity derived from the peak. A cooldown then masks
//               rebound samples.
//               Optional feature macro: DRUM_TRIG_HITCNT_EN (accepted-hit
//               counter on hit_count; tied to zero when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module drum_strike_trigger #(
  parameter logic [15:0] ARM_THRESH       = 16'd2000,
  parameter logic [15:0] RELEASE_THRESH   = 16'd500,
  parameter int          COOLDOWN_SAMPLES = 8,
  parameter int          MAX_SWING        = 64,
  parameter int          VEL_SHIFT        = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [2:0]  zone_id,
  input  logic [15:0] gyro_rate,
  input  logic        hit_ready,
  output logic        hit_valid,
  output logic [2:0]  hit_zone,
  output logic [7:0]  hit_velocity,
  output logic [15:0] hit_count
);

  // One counter is shared between swing length and cooldown, so it must
  // hold the larger of the two limits.
  localparam int CNT_MAX = (MAX_SWING > COOLDOWN_SAMPLES) ? MAX_SWING : COOLDOWN_SAMPLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SWING    = 2'd1;
  localparam logic [1:0] ST_EMIT     = 2'd2;
  localparam logic [1:0] ST_COOLDOWN = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      peak;
  logic [2:0]       zone_q;
  logic [7:0]       vel_q;

  logic [15:0]      mag;
  logic [15:0]      peak_max;
  logic [15:0]      vel_shifted;
  logic [7:0]       vel_clamped;
  logic             is_down;
  logic             arm;
  logic             release_hit;
  logic             swing_last;
  logic             cool_last;
  logic             accept;

  // Rate magnitude, saturating the one value whose negation overflows.
  always_comb begin
    if (gyro_rate == 16'h8000) begin
      mag = 16'h7FFF;
    end else if (gyro_rate[15]) begin
      mag = 16'(~gyro_rate + 16'd1);
    end else begin
      mag = gyro_rate;
    end
  end

  // Qualified sample conditions and the velocity of a swing ending now.
  always_comb begin
    is_down     = gyro_rate[15];
    arm         = valid_in && is_down && (mag >= ARM_THRESH);
    release_hit = valid_in && (!is_down || (mag < RELEASE_THRESH));
    swing_last  = (cnt == CNT_W'(MAX_SWING - 1));
    cool_last   = (cnt == CNT_W'(1));
    accept      = (state == ST_EMIT) && hit_ready;
    peak_max    = (mag > peak) ? mag : peak;
    vel_shifted = peak_max >> VEL_SHIFT;
    if (vel_shifted == 16'd0) begin
      vel_clamped = 8'd1;
    end else if (vel_shifted > 16'd255) begin
      vel_clamped = 8'd255;
    end else begin
      vel_clamped = vel_shifted[7:0];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; release is checked before the swing timeout.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (arm) state_next = ST_SWING;
      end
      ST_SWING: begin
        if (valid_in) begin
          if (release_hit) begin
            state_next = ST_EMIT;
          end else if (swing_last) begin
            state_next = ST_COOLDOWN;
          end
        end
      end
      ST_EMIT: begin
        if (hit_ready) state_next = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (valid_in && cool_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Swing datapath: peak, zone, velocity capture and the shared counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      peak   <= '0;
      zone_q <= '0;
      vel_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) begin
            peak   <= mag;
            zone_q <= zone_id;
            cnt    <= CNT_W'(1);
          end
        end
        ST_SWING: begin
          if (valid_in) begin
            zone_q <= zone_id;
            peak   <= peak_max;
            if (release_hit) begin
              vel_q <= vel_clamped;
            end else if (swing_last) begin
              cnt <= CNT_W'(COOLDOWN_SAMPLES);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ST_EMIT: begin
          if (hit_ready) cnt <= CNT_W'(COOLDOWN_SAMPLES);
        end
        ST_COOLDOWN: begin
          if (valid_in) cnt <= cnt - CNT_W'(1);
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Outputs: the hit is pending for exactly as long as the FSM sits in EMIT.
  always_comb begin
    hit_valid    = (state == ST_EMIT);
    hit_zone     = zone_q;
    hit_velocity = vel_q;
  end

`ifdef DRUM_TRIG_HITCNT_EN
  logic [15:0] hit_count_q;

  // Accepted-hit counter, free-running wrap at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q <= '0;
    end else if (accept) begin
      hit_count_q <= hit_count_q + 16'd1;
    end
  end

  assign hit_count = hit_count_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign hit_count     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_drum_strike_trigger.sv
`default_nettype none
// ============================================================================
// Module      : tb_drum_strike_trigger
// Description : Self-checking bench for drum_strike_trigger. Two instances
//               (velocity shift 6 and 12) share stimulus and are compared
//               every cycle with a behavioural hit-detection model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_drum_strike_trigger;

  localparam int ARM  = 2000;
  localparam int REL  = 500;
  localparam int COOL = 8;
  localparam int MAXS = 64;

`ifdef DRUM_TRIG_HITCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [2:0]  zone_id;
  logic [15:0] gyro_rate;
  logic        hit_ready;

  logic        hit_valid,  hit_valid12;
  logic [2:0]  hit_zone,   hit_zone12;
  logic [7:0]  hit_velocity, hit_velocity12;
  logic [15:0] hit_count,  hit_count12;

  int n_assert;
  int n_fail;

  drum_strike_trigger dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .zone_id(zone_id),
    .gyro_rate(gyro_rate), .hit_ready(hit_ready), .hit_valid(hit_valid),
    .hit_zone(hit_zone), .hit_velocity(hit_velocity), .hit_count(hit_count)
  );

  drum_strike_trigger #(.VEL_SHIFT(12)) dut12 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .zone_id(zone_id),
    .gyro_rate(gyro_rate), .hit_ready(hit_ready), .hit_valid(hit_valid12),
    .hit_zone(hit_zone12), .hit_velocity(hit_velocity12), .hit_count(hit_count12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct { int zone; int peak; } hit_t;
  hit_t m_q[$];
  bit   m_sw;
  int   m_peak, m_len, m_zone, m_cool, m_count;

  function automatic int mag_of(int g);
    int m;
    m = (g < 0) ? -g : g;
    if (m > 32767) m = 32767;
    return m;
  endfunction

  function automatic int vel_of(int pk, int sh);
    int v;
    v = pk >> sh;
    if (v < 1) v = 1;
    if (v > 255) v = 255;
    return v;
  endfunction

  task automatic model_update(input bit v, input int z, input int g, input bit r, input bit rs);
    int mg;
    mg = mag_of(g);
    if (rs) begin
      m_sw = 0; m_peak = 0; m_len = 0; m_cool = 0; m_count = 0;
      m_q.delete();
    end else if (m_q.size() > 0) begin
      if (r) begin
        void'(m_q.pop_front());
        m_cool  = COOL;
        m_count = (m_count + 1) % 65536;
      end
    end else if (m_cool > 0) begin
      if (v) m_cool--;
    end else if (m_sw) begin
      if (v) begin
        m_zone = z;
        if (mg > m_peak) m_peak = mg;
        m_len++;
        if (g >= 0 || mg < REL) begin
          m_q.push_back('{m_zone, m_peak});
          m_sw = 0;
        end else if (m_len >= MAXS) begin
          m_sw   = 0;
          m_cool = COOL;
        end
      end
    end else if (v && g < 0 && mg >= ARM) begin
      m_sw = 1; m_peak = mg; m_len = 1; m_zone = z;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input bit rs);
    bit ev;
    ev = (m_q.size() > 0);
    chk("hit_valid",   32'(hit_valid),   32'(ev));
    chk("hit_valid12", 32'(hit_valid12), 32'(ev));
    if (ev) begin
      chk("hit_zone",       32'(hit_zone),       32'(m_q[0].zone & 7));
      chk("hit_velocity",   32'(hit_velocity),   32'(vel_of(m_q[0].peak, 6)));
      chk("hit_velocity12", 32'(hit_velocity12), 32'(vel_of(m_q[0].peak, 12)));
    end
    if (rs) begin
      chk("rst_zone", 32'(hit_zone),     32'd0);
      chk("rst_vel",  32'(hit_velocity), 32'd0);
    end
    chk("hit_count",   32'(hit_count),   CNT_EN ? 32'(m_count) : 32'd0);
    chk("hit_count12", 32'(hit_count12), CNT_EN ? 32'(m_count) : 32'd0);
  endtask

  task automatic step(input bit v, input int z, input int g, input bit r, input bit rs);
    valid_in  = v;
    zone_id   = 3'(z);
    gyro_rate = 16'(g);
    hit_ready = r;
    rst       = rs;
    @(posedge clk);
    model_update(v, z, g, r, rs);
    #1;
    compare_all(rs);
  endtask

  task automatic flush();
    for (int i = 0; i < COOL + 1; i++) step(1'b1, 0, 0, 1'b1, 1'b0);
  endtask

  function automatic int rand_rate();
    int k;
    k = $urandom_range(0, 9);
    if (k < 4)      return -int'($urandom_range(2000, 32768));
    else if (k < 6) return int'($urandom_range(0, 998)) - 499;
    else if (k < 8) return -int'($urandom_range(500, 1999));
    else            return int'($urandom_range(0, 32767));
  endfunction

  initial begin
    n_assert = 0; n_fail = 0;
    m_sw = 0; m_peak = 0; m_len = 0; m_zone = 0; m_cool = 0; m_count = 0;
    rst = 1'b1; valid_in = 1'b0; zone_id = '0; gyro_rate = '0; hit_ready = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 4; i++)
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), rand_rate(),
           1'($urandom_range(0, 1)), 1'b1);
    step(1'b0, 0, 0, 1'b0, 1'b0);

    // Basic swing: peak 9000 -> velocity 140, zone from release sample
    step(1'b1, 1, -3000, 1'b1, 1'b0);
    step(1'b1, 3, -9000, 1'b1, 1'b0);
    step(1'b1, 0, -6000, 1'b1, 1'b0);
    step(1'b1, 2, -400,  1'b1, 1'b0);
    chk("d_basic_valid", 32'(hit_valid),    32'd1);
    chk("d_basic_zone",  32'(hit_zone),     32'd2);
    chk("d_basic_vel",   32'(hit_velocity), 32'd140);
    step(1'b0, 0, 0, 1'b1, 1'b0);
    chk("d_basic_onecycle", 32'(hit_valid), 32'd0);

    // Cooldown masks 8 samples, the 9th arms
    for (int i = 0; i < COOL; i++) step(1'b1, 1, -5000, 1'b1, 1'b0);
    step(1'b1, 1, -5000, 1'b1, 1'b0);
    step(1'b1, 3, -100,  1'b1, 1'b0);
    chk("d_cool_valid", 32'(hit_valid),    32'd1);
    chk("d_cool_vel",   32'(hit_velocity), 32'd78);
    chk("d_count1",     32'(hit_count),    CNT_EN ? 32'd1 : 32'd0);
    step(1'b0, 0, 0, 1'b1, 1'b0);
    chk("d_count2",     32'(hit_count),    CNT_EN ? 32'd2 : 32'd0);
    flush();

    // Velocity clamps
    step(1'b1, 0, -32768, 1'b1, 1'b0);
    step(1'b1, 1, -100,   1'b1, 1'b0);
    chk("d_vel_max",   32'(hit_velocity),   32'd255);
    chk("d_vel_max12", 32'(hit_velocity12), 32'd7);
    step(1'b0, 0, 0, 1'b1, 1'b0);
    flush();
    step(1'b1, 0, -2000, 1'b1, 1'b0);
    step(1'b1, 0, -100,  1'b1, 1'b0);
    chk("d_vel_min12", 32'(hit_velocity12), 32'd1);
    chk("d_vel_2000",  32'(hit_velocity),   32'd31);
    step(1'b0, 0, 0, 1'b1, 1'b0);
    flush();

    // Backpressure: hit held stable, swing during EMIT ignored
    step(1'b1, 1, -8000, 1'b0, 1'b0);
    step(1'b1, 3, 0,     1'b0, 1'b0);
    step(1'b1, 0, -6000, 1'b0, 1'b0);
    step(1'b1, 0, -7000, 1'b0, 1'b0);
    step(1'b1, 1, -3000, 1'b0, 1'b0);
    step(1'b1, 2, -100,  1'b0, 1'b0);
    step(1'b1, 2, -200,  1'b0, 1'b0);
    chk("d_bp_valid", 32'(hit_valid),    32'd1);
    chk("d_bp_zone",  32'(hit_zone),     32'd3);
    chk("d_bp_vel",   32'(hit_velocity), 32'd125);
    step(1'b0, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b1, 1'b0);
    flush();

    // Swing timeout at 64 samples, then release on sample 64
    for (int i = 0; i < MAXS; i++) step(1'b1, 1, -3000, 1'b1, 1'b0);
    chk("d_timeout_nohit", 32'(hit_valid), 32'd0);
    step(1'b1, 1, -5000, 1'b1, 1'b0);
    step(1'b1, 1, -400,  1'b1, 1'b0);
    chk("d_timeout_cool", 32'(hit_valid), 32'd0);
    flush();
    for (int i = 0; i < MAXS - 1; i++) step(1'b1, 1, -3000, 1'b1, 1'b0);
    step(1'b1, 2, -100, 1'b0, 1'b0);
    chk("d_rel64_valid", 32'(hit_valid),    32'd1);
    chk("d_rel64_vel",   32'(hit_velocity), 32'd46);
    step(1'b0, 0, 0, 1'b1, 1'b0);
    flush();

    // Reset during SWING and during EMIT discards the event
    step(1'b1, 1, -4000, 1'b1, 1'b0);
    step(1'b1, 1, -4000, 1'b1, 1'b1);
    step(1'b1, 1, -100,  1'b1, 1'b0);
    chk("d_rst_swing", 32'(hit_valid), 32'd0);
    step(1'b1, 1, -4000, 1'b0, 1'b0);
    step(1'b1, 1, -100,  1'b0, 1'b0);
    step(1'b0, 0, 0,     1'b0, 1'b1);
    chk("d_rst_emit", 32'(hit_valid), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), rand_rate(),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 149) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/drum_strike_trigger.md
DRUM_STRIKE_TRIGGER -- requirements
Module: drum_strike_trigger

Interface
REQ-001 Parameter ARM_THRESH, 16'd2000, downward gyro rate magnitude (LSB units) that arms a swing.
REQ-002 Parameter RELEASE_THRESH, 16'd500, magnitude below which an armed swing is considered struck.
REQ-003 Parameter COOLDOWN_SAMPLES, 8, valid samples ignored after each accepted hit.
REQ-004 Parameter MAX_SWING, 64, valid samples allowed in SWING before abort.
REQ-005 Parameter VEL_SHIFT, 6, right shift applied to peak magnitude to form velocity.
REQ-006 clk  in  1  single clock; all logic on posedge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 valid_in  in  1  zone_id and gyro_rate valid this cycle (the zone detector's valid_out).
REQ-009 zone_id  in  3  0=snare, 1=high tom, 2=mid tom, 3=floor tom.
REQ-010 gyro_rate  in  16  signed pitch rate, two's complement; negative = downward swing.
REQ-011 hit_ready  in  1  consumer accepts hit this cycle.
REQ-012 hit_valid  out  1  hit event pending.
REQ-013 hit_zone  out  3  zone of the hit.
REQ-014 hit_velocity  out  8  strike velocity, 1..255.
REQ-015 hit_count  out  16  accepted-hit counter (see Configuration).

Function
REQ-016 States IDLE, SWING, EMIT, COOLDOWN; inputs are sampled only in cycles with valid_in=1.
REQ-017 mag = |gyro_rate|, with -32768 saturating to 32767.
REQ-018 IDLE: a sample with gyro_rate<0 and mag>=ARM_THRESH -> SWING; peak<=mag, zone latched, swing counter<=1.
REQ-019 SWING: each sample latches zone_id; peak<=max(peak,mag); swing counter increments.
REQ-020 SWING: a sample with gyro_rate>=0 or mag<RELEASE_THRESH -> EMIT; zone latched from that sample.
REQ-021 SWING: if the counter reaches MAX_SWING without release -> COOLDOWN, no hit emitted.
REQ-022 Release takes priority over timeout on the same sample.
REQ-023 EMIT: hit_valid=1 starting the cycle after the release sample (latency 1 clk); hit_zone and hit_velocity are held stable until accepted.
REQ-024 hit_velocity = peak>>VEL_SHIFT, clamped to the range 1..255.
REQ-025 A hit is accepted in a cycle with hit_valid=1 and hit_ready=1; in the next cycle hit_valid=0 and the state is COOLDOWN with the counter loaded to COOLDOWN_SAMPLES.
REQ-026 hit_valid never deasserts without acceptance; valid_in samples are ignored in EMIT.
REQ-027 COOLDOWN: each sample decrements the counter; the sample that reaches 0 moves the state to IDLE and cannot itself arm.
REQ-028 hit_ready is ignored when hit_valid=0.

Reset
REQ-029 rst=1 forces IDLE, hit_valid=0, hit_zone=0, hit_velocity=0, hit_count=0, and clears the peak and both counters on the next posedge.
REQ-030 A reset during SWING or EMIT discards the pending swing or hit with no output.

Configuration
REQ-031 Macro DRUM_TRIG_HITCNT_EN defined: hit_count increments by 1 on each accepted hit and wraps 65535->0.
REQ-032 Macro DRUM_TRIG_HITCNT_EN undefined: hit_count is tied to 0 and no counter logic exists.

Verification
REQ-033 Reset asserted with random inputs -> all outputs 0 and the state is IDLE.
REQ-034 Samples -3000, -9000, -6000, -400 with zone 2 on the last sample and hit_ready=1 -> one-cycle hit_valid the clock after -400, hit_zone=2, hit_velocity=140.
REQ-035 Peak sample of -32768 followed by -100 -> hit_velocity=255; peak of -2000 with VEL_SHIFT=12 -> hit_velocity=1.
REQ-036 hit_ready held low for 5 cycles while a new swing is applied -> hit_valid, hit_zone and hit_velocity stay stable; the new swing produces no second hit.
REQ-037 After acceptance, -5000 on cooldown samples 1-8 -> ignored; -5000 on sample 9 arms; with DRUM_TRIG_HITCNT_EN defined, hit_count=1, then 2 after the next accepted hit.
REQ-038 64 consecutive -3000 samples -> no hit and the state is COOLDOWN; a release on sample 64 -> hit emitted instead.
